// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder.
//   state_t                 : control FSM encoding (S_IDLE, S_RUN, S_DONE)
//   SERIAL_ADDER_MIN_WIDTH  : smallest legal WIDTH for serial_adder
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADDER_MIN_WIDTH = 2;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder cell.
// Ports:
//   a, b   : addend bits
//   c_in   : carry in
//   s      : sum bit
//   c_out  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial, LSB-first adder built around one full_adder cell with a
// registered carry loop. Operands are accepted over a valid/ready handshake,
// one bit pair is processed per cycle, and the WIDTH-bit sum plus carry-out
// are presented over a second valid/ready handshake.
//
// Parameters:
//   WIDTH      : operand/sum width, WIDTH >= SERIAL_ADDER_MIN_WIDTH (2)
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : a, b, c_in are valid
//   in_ready   : block can accept operands (state == S_IDLE)
//   a, b       : WIDTH-bit addends
//   c_in       : carry in
//   out_valid  : sum / c_out are valid (state == S_DONE)
//   out_ready  : consumer accepts the result
//   sum        : low WIDTH bits of a + b + c_in
//   c_out      : carry out of bit WIDTH-1
//   ovf        : two's-complement signed overflow (only with
//                SERIAL_ADDER_OVF_EN defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_out_q,  c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    full_adder u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = c_in;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
                sum_sr_d           = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]  = fa_s;
                carry_d            = fa_c;
                a_sr_d             = a_sr_q >> 1;
                b_sr_d             = b_sr_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    // Result registers load only here, so the outputs hold the
                    // last result through IDLE and the next operation's RUN.
                    state_d = S_DONE;
                    sum_d   = sum_sr_d;
                    c_out_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final bit.
                    ovf_d   = carry_q ^ fa_c;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed, table-driven bench for serial_adder: a WIDTH=8 instance for the
// vector table and multi-cycle corner cases, and a WIDTH=2 instance for the
// exhaustive back-to-back sweep.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst_n;

    // WIDTH = 8 instance
    logic       in_valid, in_ready, out_valid, out_ready, c_in, c_out;
    logic [7:0] a, b, sum;
    // WIDTH = 2 instance
    logic       in_valid2, in_ready2, out_valid2, c_in2, c_out2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf2;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .sum(sum2), .c_out(c_out2)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ticks until out_valid; returns cycles since the acceptance edge.
    task automatic wait_valid8(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
            tick();
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // One full operation on the WIDTH=8 instance with out_ready high.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                          input logic [7:0] es, input logic eco, input logic eov);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        a = ta; b = tb_; c_in = tci; in_valid = 1'b1;
        tick();                       // acceptance edge (edge 0)
        in_valid = 1'b0;
        wait_valid8(n);
        chk("latency", n, 32'd8);
        chk("sum", {24'b0, sum}, {24'b0, es});
        chk("c_out", {31'b0, c_out}, {31'b0, eco});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", {31'b0, ovf}, {31'b0, eov});
`else
        if (eov === 1'bx) $display("note: unknown ovf expectation");
`endif
        tick();                       // result taken, back to idle
        chk("in_ready_after", {31'b0, in_ready}, 32'd1);
        chk("out_valid_after", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int prev_acc;
        logic [2:0] exp3;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; c_in = 0; out_ready = 1;
        in_valid2 = 0; a2 = 0; b2 = 0; c_in2 = 0;
        #22;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_c_out", {31'b0, c_out}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ov);

        // Backpressure: result held, second request ignored.
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; c_in = 0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid8(n);
        chk("bp_latency", n, 32'd8);
        a = 8'hFF; b = 8'h00; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_sum", {24'b0, sum}, 32'h46);
            chk("bp_c_out", {31'b0, c_out}, 32'd0);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
        chk("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
        chk("bp_sum_kept", {24'b0, sum}, 32'h46);

        // Reset mid-operation.
        a = 8'h0F; b = 8'h01; c_in = 0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #2;
        chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mr_sum", {24'b0, sum}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mr_still_idle", {31'b0, out_valid}, 32'd0);
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // WIDTH=2: all 32 combinations back-to-back, one result per 4 cycles.
        prev_acc = 0;
        in_valid2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a2 = i[4:3]; b2 = i[2:1]; c_in2 = i[0];
            exp3 = {1'b0, a2} + {1'b0, b2} + {2'b0, c_in2};
            n = 0;
            while (!in_ready2 && n < 10) begin
                tick();
                n++;
            end
            if (!in_ready2) chk("w2_ready_timeout", 32'd0, 32'd1);
            if (i > 0) chk("w2_spacing", cyc - prev_acc, 32'd4);
            prev_acc = cyc;
            tick();
            n = 0;
            while (!out_valid2 && n < 10) begin
                tick();
                n++;
            end
            chk("w2_latency", n, 32'd2);
            chk("w2_result", {29'b0, c_out2, sum2}, {29'b0, exp3});
        end
        in_valid2 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
